// File: rtl/bk_resp_checker.sv
// bk_resp_checker
//   In-order response checker for the 16-bit Brent-Kung adder datapath.
//   Operand sets pushed on the stimulus side are turned into golden
//   {carry, sum} values and queued; each DUT response pops the queue head
//   and is compared against it.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               synchronous clear of FIFO, counters, flags and state
//   stim_valid/ready  operand handshake; stim_a, stim_b, stim_cin operands
//   rsp_valid         DUT result strobe (no backpressure); rsp_sum, rsp_carry
//   pass_cnt/fail_cnt saturating match/mismatch counters
//   fail_seen         sticky mismatch flag; fail_exp/fail_got first mismatch
//   orphan_err        sticky: response arrived while FIFO empty
//   pending           FIFO occupancy (0..DEPTH)
//   halted            checker stopped after a mismatch (STOP_ON_FAIL=1)
module bk_resp_checker #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CNT_W        = 16,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       stim_valid,
    output logic                       stim_ready,
    input  logic [WIDTH-1:0]           stim_a,
    input  logic [WIDTH-1:0]           stim_b,
    input  logic                       stim_cin,
    input  logic                       rsp_valid,
    input  logic [WIDTH-1:0]           rsp_sum,
    input  logic                       rsp_carry,
    output logic [CNT_W-1:0]           pass_cnt,
    output logic [CNT_W-1:0]           fail_cnt,
    output logic                       fail_seen,
    output logic [WIDTH:0]             fail_exp,
    output logic [WIDTH:0]             fail_got,
    output logic                       orphan_err,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       halted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH:0]      mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       count_q, count_d;
    logic [CNT_W-1:0]    pass_q, pass_d;
    logic [CNT_W-1:0]    fail_q, fail_d;
    logic                seen_q, seen_d;
    logic [WIDTH:0]      fexp_q, fexp_d;
    logic [WIDTH:0]      fgot_q, fgot_d;
    logic                orph_q, orph_d;
    // Holds stim_ready low until the first clock edge after reset release.
    logic                alive_q;

    logic                run;
    logic                push;
    logic                pop;
    logic                orphan_hit;
    logic                match;
    logic [WIDTH:0]      head;
    logic [WIDTH:0]      got;
    logic [WIDTH:0]      exp_w;

    assign run        = (state_q == ST_RUN);
    assign head       = mem_q[rd_ptr_q];
    assign got        = {rsp_carry, rsp_sum};
    assign match      = (head == got);
    assign exp_w      = {1'b0, stim_a} + {1'b0, stim_b} + {{WIDTH{1'b0}}, stim_cin};
    assign push       = stim_valid && stim_ready;
    assign pop        = rsp_valid && run && (count_q != '0);
    assign orphan_hit = rsp_valid && run && (count_q == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_RUN;
        end else if (pop && !match && STOP_ON_FAIL) begin
            state_d = ST_HALT;
        end
    end

    // Output logic
    always_comb begin
        halted     = (state_q == ST_HALT);
        stim_ready = alive_q && (state_q == ST_RUN) && (count_q < PW'(DEPTH));
    end

    // FIFO pointers, counters and mismatch capture
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        seen_d   = seen_q;
        fexp_d   = fexp_q;
        fgot_d   = fgot_q;
        orph_d   = orph_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            pass_d   = '0;
            fail_d   = '0;
            seen_d   = 1'b0;
            fexp_d   = '0;
            fgot_d   = '0;
            orph_d   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                if (match) begin
                    if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
                end else begin
                    if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
                    seen_d = 1'b1;
                    if (!seen_q) begin
                        fexp_d = head;
                        fgot_d = got;
                    end
                end
            end
            if (orphan_hit) begin
                orph_d = 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + PW'(1);
                2'b01:   count_d = count_q - PW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            seen_q   <= 1'b0;
            fexp_q   <= '0;
            fgot_q   <= '0;
            orph_q   <= 1'b0;
            alive_q  <= 1'b0;
        end else begin
            if (!clr && push) mem_q[wr_ptr_q] <= exp_w;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            seen_q   <= seen_d;
            fexp_q   <= fexp_d;
            fgot_q   <= fgot_d;
            orph_q   <= orph_d;
            alive_q  <= 1'b1;
        end
    end

    assign pass_cnt   = pass_q;
    assign fail_cnt   = fail_q;
    assign fail_seen  = seen_q;
    assign fail_exp   = fexp_q;
    assign fail_got   = fgot_q;
    assign orphan_err = orph_q;
    assign pending    = count_q;

endmodule

// File: tb/tb_bk_resp_checker.sv
// tb_bk_resp_checker
//   Directed bench for bk_resp_checker. Instance A uses CNT_W=4 (saturation),
//   instance B uses STOP_ON_FAIL=1. Stimulus pushes hand-computed
//   expectations into a queue; a monitor drains and compares it on each
//   falling clock edge.
module tb_bk_resp_checker;

  localparam int F_PASS = 0;
  localparam int F_FAIL = 1;
  localparam int F_SEEN = 2;
  localparam int F_EXP  = 3;
  localparam int F_GOT  = 4;
  localparam int F_ORPH = 5;
  localparam int F_PEND = 6;
  localparam int F_RDY  = 7;
  localparam int F_HALT = 8;

  logic clk;
  logic rst_n;

  logic        a_clr, a_sv, a_sc, a_rv, a_rc;
  logic [15:0] a_sa, a_sb, a_rs;
  logic        a_rdy, a_seen, a_orph, a_halt;
  logic [3:0]  a_pass, a_fail;
  logic [16:0] a_exp, a_got;
  logic [3:0]  a_pend;

  logic        b_clr, b_sv, b_sc, b_rv, b_rc;
  logic [15:0] b_sa, b_sb, b_rs;
  logic        b_rdy, b_seen, b_orph, b_halt;
  logic [15:0] b_pass, b_fail;
  logic [16:0] b_exp, b_got;
  logic [3:0]  b_pend;

  bk_resp_checker #(.WIDTH(16), .DEPTH(8), .CNT_W(4), .STOP_ON_FAIL(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr),
    .stim_valid(a_sv), .stim_ready(a_rdy), .stim_a(a_sa), .stim_b(a_sb), .stim_cin(a_sc),
    .rsp_valid(a_rv), .rsp_sum(a_rs), .rsp_carry(a_rc),
    .pass_cnt(a_pass), .fail_cnt(a_fail), .fail_seen(a_seen),
    .fail_exp(a_exp), .fail_got(a_got), .orphan_err(a_orph),
    .pending(a_pend), .halted(a_halt)
  );

  bk_resp_checker #(.WIDTH(16), .DEPTH(8), .CNT_W(16), .STOP_ON_FAIL(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr),
    .stim_valid(b_sv), .stim_ready(b_rdy), .stim_a(b_sa), .stim_b(b_sb), .stim_cin(b_sc),
    .rsp_valid(b_rv), .rsp_sum(b_rs), .rsp_carry(b_rc),
    .pass_cnt(b_pass), .fail_cnt(b_fail), .fail_seen(b_seen),
    .fail_exp(b_exp), .fail_got(b_got), .orphan_err(b_orph),
    .pending(b_pend), .halted(b_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          inst;
    int          fld;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] get(input int inst, input int fld);
    if (inst == 0) begin
      case (fld)
        F_PASS:  return 32'(a_pass);
        F_FAIL:  return 32'(a_fail);
        F_SEEN:  return 32'(a_seen);
        F_EXP:   return 32'(a_exp);
        F_GOT:   return 32'(a_got);
        F_ORPH:  return 32'(a_orph);
        F_PEND:  return 32'(a_pend);
        F_RDY:   return 32'(a_rdy);
        default: return 32'(a_halt);
      endcase
    end
    case (fld)
      F_PASS:  return 32'(b_pass);
      F_FAIL:  return 32'(b_fail);
      F_SEEN:  return 32'(b_seen);
      F_EXP:   return 32'(b_exp);
      F_GOT:   return 32'(b_got);
      F_ORPH:  return 32'(b_orph);
      F_PEND:  return 32'(b_pend);
      F_RDY:   return 32'(b_rdy);
      default: return 32'(b_halt);
    endcase
  endfunction

  task automatic ea(input int fld, input logic [31:0] v, input string n);
    q.push_back('{0, fld, v, n});
  endtask

  task automatic eb(input int fld, input logic [31:0] v, input string n);
    q.push_back('{1, fld, v, n});
  endtask

  exp_t        m_e;
  logic [31:0] m_act;
  always @(negedge clk) begin
    while (q.size() > 0) begin
      m_e   = q.pop_front();
      m_act = get(m_e.inst, m_e.fld);
      checks++;
      if (m_act !== m_e.val) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", m_e.name, m_act, m_e.val);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_step(input logic sv, input logic [15:0] sa, input logic [15:0] sb,
                        input logic sc, input logic rv, input logic [16:0] r, input logic cl);
    a_sv = sv; a_sa = sa; a_sb = sb; a_sc = sc;
    a_rv = rv; a_rs = r[15:0]; a_rc = r[16]; a_clr = cl;
    cyc();
    a_sv = 1'b0; a_rv = 1'b0; a_clr = 1'b0;
  endtask

  task automatic b_step(input logic sv, input logic [15:0] sa, input logic [15:0] sb,
                        input logic sc, input logic rv, input logic [16:0] r, input logic cl);
    b_sv = sv; b_sa = sa; b_sb = sb; b_sc = sc;
    b_rv = rv; b_rs = r[15:0]; b_rc = r[16]; b_clr = cl;
    cyc();
    b_sv = 1'b0; b_rv = 1'b0; b_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_clr = 0; a_sv = 0; a_sa = 0; a_sb = 0; a_sc = 0; a_rv = 0; a_rs = 0; a_rc = 0;
    b_clr = 0; b_sv = 0; b_sa = 0; b_sb = 0; b_sc = 0; b_rv = 0; b_rs = 0; b_rc = 0;

    ea(F_PEND, 0, "rst_pend"); ea(F_PASS, 0, "rst_pass"); ea(F_RDY, 0, "rst_rdy");
    ea(F_HALT, 0, "rst_halt"); eb(F_HALT, 0, "b_rst_halt"); eb(F_RDY, 0, "b_rst_rdy");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ea(F_RDY, 0, "rdy_before_first_clk");
    cyc();
    ea(F_RDY, 1, "rdy_after_first_clk"); eb(F_RDY, 1, "b_rdy_after_first_clk");

    a_step(1, 16'h0001, 16'h0002, 0, 0, 17'h0, 0);
    ea(F_PEND, 1, "t1_pend_push");
    a_step(0, 0, 0, 0, 1, 17'h00003, 0);
    ea(F_PASS, 1, "t1_pass"); ea(F_FAIL, 0, "t1_fail");
    ea(F_PEND, 0, "t1_pend"); ea(F_ORPH, 0, "t1_orph");

    a_step(1, 16'hFFFF, 16'h0001, 0, 0, 17'h0, 0);
    a_step(0, 0, 0, 0, 1, 17'h00000, 0);
    ea(F_FAIL, 1, "t2_fail1"); ea(F_SEEN, 1, "t2_seen");
    ea(F_EXP, 32'h10000, "t2_exp"); ea(F_GOT, 0, "t2_got");
    a_step(1, 16'h0003, 16'h0004, 1, 0, 17'h0, 0);
    a_step(0, 0, 0, 0, 1, 17'h00009, 0);
    ea(F_FAIL, 2, "t2_fail2"); ea(F_EXP, 32'h10000, "t2_exp_kept");
    ea(F_GOT, 0, "t2_got_kept"); ea(F_PASS, 1, "t2_pass");

    for (int unsigned i = 0; i < 9; i++) a_step(1, 16'(i), 16'(i), 0, 0, 17'h0, 0);
    ea(F_PEND, 8, "t3_full_pend"); ea(F_RDY, 0, "t3_full_rdy");
    a_step(0, 0, 0, 0, 1, 17'h00000, 0);
    ea(F_PEND, 7, "t3_pop_pend"); ea(F_RDY, 1, "t3_pop_rdy"); ea(F_PASS, 2, "t3_pop_pass");
    for (int unsigned i = 1; i < 4; i++) a_step(0, 0, 0, 0, 1, 17'(2 * i), 0);
    ea(F_PEND, 4, "t3_pend4"); ea(F_PASS, 5, "t3_pass5");
    a_step(1, 16'h0100, 16'h0200, 1, 1, 17'h00008, 0);
    ea(F_PEND, 4, "t3_pushpop_pend"); ea(F_PASS, 6, "t3_pushpop_pass");
    for (int unsigned i = 5; i < 8; i++) a_step(0, 0, 0, 0, 1, 17'(2 * i), 0);
    a_step(0, 0, 0, 0, 1, 17'h00301, 0);
    ea(F_PEND, 0, "t3_drain_pend"); ea(F_PASS, 10, "t3_drain_pass"); ea(F_FAIL, 2, "t3_drain_fail");

    a_step(0, 0, 0, 0, 1, 17'h01234, 0);
    ea(F_ORPH, 1, "t4_orph"); ea(F_PASS, 10, "t4_pass"); ea(F_FAIL, 2, "t4_fail");
    ea(F_PEND, 0, "t4_pend");
    a_step(1, 16'h0001, 16'h0001, 0, 1, 17'h00002, 1);
    ea(F_PASS, 0, "clr_pass"); ea(F_FAIL, 0, "clr_fail"); ea(F_SEEN, 0, "clr_seen");
    ea(F_EXP, 0, "clr_exp"); ea(F_GOT, 0, "clr_got"); ea(F_ORPH, 0, "clr_orph");
    ea(F_PEND, 0, "clr_pend"); ea(F_RDY, 1, "clr_rdy");
    a_step(1, 16'h0005, 16'h0005, 0, 1, 17'h0000A, 0);
    ea(F_PEND, 1, "t4_push_pend"); ea(F_ORPH, 1, "t4_push_orph"); ea(F_PASS, 0, "t4_push_pass");
    a_step(0, 0, 0, 0, 1, 17'h0000A, 0);
    ea(F_PASS, 1, "t4_late_pass"); ea(F_PEND, 0, "t4_late_pend");

    a_step(0, 0, 0, 0, 0, 17'h0, 1);
    for (int unsigned i = 0; i < 17; i++) begin
      a_step(1, 16'(i), 16'h0000, 0, 0, 17'h0, 0);
      a_step(0, 0, 0, 0, 1, 17'(i), 0);
    end
    ea(F_PASS, 15, "t5_pass_sat"); ea(F_FAIL, 0, "t5_fail");

    for (int unsigned i = 0; i < 3; i++) a_step(1, 16'(i), 16'h0001, 0, 0, 17'h0, 0);
    ea(F_PEND, 3, "t6_pend3");
    cyc();
    rst_n = 1'b0;
    ea(F_PEND, 0, "t6_rst_pend"); ea(F_PASS, 0, "t6_rst_pass"); ea(F_RDY, 0, "t6_rst_rdy");
    cyc();
    rst_n = 1'b1;
    cyc();

    b_step(1, 16'h0001, 16'h0001, 0, 0, 17'h0, 0);
    b_step(1, 16'h0002, 16'h0002, 0, 0, 17'h0, 0);
    eb(F_PEND, 2, "b_pend2");
    b_step(0, 0, 0, 0, 1, 17'h00005, 0);
    eb(F_HALT, 1, "b_halt"); eb(F_RDY, 0, "b_halt_rdy"); eb(F_FAIL, 1, "b_fail");
    eb(F_SEEN, 1, "b_seen"); eb(F_EXP, 2, "b_exp"); eb(F_GOT, 5, "b_got");
    eb(F_PEND, 1, "b_halt_pend");
    b_step(1, 16'h0007, 16'h0007, 0, 1, 17'h00004, 0);
    eb(F_PASS, 0, "b_frozen_pass"); eb(F_FAIL, 1, "b_frozen_fail");
    eb(F_PEND, 1, "b_frozen_pend"); eb(F_HALT, 1, "b_still_halt");
    b_step(0, 0, 0, 0, 1, 17'h00004, 0);
    b_step(0, 0, 0, 0, 1, 17'h00004, 0);
    eb(F_ORPH, 0, "b_no_orph"); eb(F_PEND, 1, "b_pend_kept");
    b_step(0, 0, 0, 0, 0, 17'h0, 1);
    eb(F_HALT, 0, "b_clr_halt"); eb(F_RDY, 1, "b_clr_rdy"); eb(F_PASS, 0, "b_clr_pass");
    eb(F_FAIL, 0, "b_clr_fail"); eb(F_SEEN, 0, "b_clr_seen"); eb(F_EXP, 0, "b_clr_exp");
    eb(F_GOT, 0, "b_clr_got"); eb(F_PEND, 0, "b_clr_pend");

    @(negedge clk);
    #1;
    checks++;
    if (b_halt !== 1'b0) begin
      errors++;
      $display("FAIL b_final_halt: got 0x%0h expected 0x0", b_halt);
    end
    checks++;
    if (b_rdy !== 1'b1) begin
      errors++;
      $display("FAIL b_final_rdy: got 0x%0h expected 0x1", b_rdy);
    end
    checks++;
    if (b_pend !== 4'd0) begin
      errors++;
      $display("FAIL b_final_pend: got 0x%0h expected 0x0", b_pend);
    end
    checks++;
    if (b_pass !== 16'd0) begin
      errors++;
      $display("FAIL b_final_pass: got 0x%0h expected 0x0", b_pass);
    end
    checks++;
    if (b_seen !== 1'b0) begin
      errors++;
      $display("FAIL b_final_seen: got 0x%0h expected 0x0", b_seen);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    if (errors == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
